// File: rtl/uart_pkg.sv
// Shared types and constants for the IO1 UART: FSM state encoding, register map, STATUS bit positions.
// No logic here; latency and backpressure are defined by the modules that import it.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    typedef uart_state_t tx_state_t;
    typedef uart_state_t rx_state_t;

    localparam logic [1:0] REG_DATA   = 2'b00;
    localparam logic [1:0] REG_STATUS = 2'b01;
    localparam logic [1:0] REG_DIV    = 2'b10;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAMING    = 3;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter: start loads a full or half period, tick pulses for one cycle
// at each period end, then the counter reloads a full period by itself. No backpressure.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] divisor,
    input  logic       start,
    input  logic       half,
    output logic       tick
);

    localparam int CW = $clog2(256 * PRESCALE);
    localparam int LW = CW + 1;

    logic [CW-1:0] cnt;
    logic [LW-1:0] fullLen;
    logic [LW-1:0] loadLen;

    // One extra bit: the longest period, 256*PRESCALE, does not fit in CW bits.
    assign fullLen = LW'(divisor) * LW'(PRESCALE) + LW'(PRESCALE);
    assign loadLen = half ? (fullLen >> 1) : fullLen;
    assign tick    = (cnt == '0) && !start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(loadLen - LW'(1));
        end else if (cnt == '0) begin
            cnt <= CW'(fullLen - LW'(1));
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/io1_uart.sv
// Memory-mapped 8N1 UART on IO1: DATA/STATUS/DIVISOR registers, single TX and RX holding registers.
// Reads are combinational; a DATA write while txBusy is dropped, an unread RX byte is overwritten (overrun).
module io1_uart
    import uart_pkg::*;
#(
    parameter int         PRESCALE  = 16,
    parameter logic [7:0] DIV_RESET = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       readEnable,
    input  logic       writeEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    input  logic       rx,
    output logic       tx
);

    logic [7:0] divisor;
    tx_state_t  txState;
    rx_state_t  rxState;
    logic [7:0] txShift, rxShift, rxData;
    logic [2:0] txBitCnt, rxBitCnt;
    logic       rxSync1, rxSync2, rxPrev;
    logic       rxValid, rxOverrun, framingError;
    logic       txBusy, txLoad, txTick, rxTick, rxStart, rxFall;
    logic       statusWr, rxStopOk, rxStopBad;
    logic [7:0] status;

    assign txBusy    = (txState != IDLE);
    assign txLoad    = writeEnable && (regSelect == REG_DATA) && !txBusy;
    assign statusWr  = writeEnable && (regSelect == REG_STATUS);
    assign rxFall    = rxPrev && !rxSync2;
    assign rxStart   = (rxState == IDLE) && rxFall;
    assign rxStopOk  = (rxState == STOP) && rxTick && rxSync2;
    assign rxStopBad = (rxState == STOP) && rxTick && !rxSync2;
    assign status    = {4'b0, framingError, rxOverrun, rxValid, txBusy};

    uart_bit_timer #(.PRESCALE(PRESCALE)) txTimer (
        .clk(clk), .reset(reset), .divisor(divisor),
        .start(txLoad), .half(1'b0), .tick(txTick)
    );

    // RX timer is started half a period in so every later tick lands mid-bit.
    uart_bit_timer #(.PRESCALE(PRESCALE)) rxTimer (
        .clk(clk), .reset(reset), .divisor(divisor),
        .start(rxStart), .half(1'b1), .tick(rxTick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor <= DIV_RESET;
        end else if (writeEnable && (regSelect == REG_DIV)) begin
            divisor <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState  <= IDLE;
            tx       <= 1'b1;
            txShift  <= '0;
            txBitCnt <= '0;
        end else begin
            case (txState)
                IDLE: if (txLoad) begin
                    txShift <= dataIn;
                    tx      <= 1'b0;
                    txState <= START;
                end
                START: if (txTick) begin
                    tx       <= txShift[0];
                    txShift  <= txShift >> 1;
                    txBitCnt <= '0;
                    txState  <= DATA;
                end
                DATA: if (txTick) begin
                    if (txBitCnt == 3'd7) begin
                        tx      <= 1'b1;
                        txState <= STOP;
                    end else begin
                        tx       <= txShift[0];
                        txShift  <= txShift >> 1;
                        txBitCnt <= txBitCnt + 3'd1;
                    end
                end
                STOP: if (txTick) txState <= IDLE;
                default: txState <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxSync1  <= 1'b1;
            rxSync2  <= 1'b1;
            rxPrev   <= 1'b1;
            rxState  <= IDLE;
            rxShift  <= '0;
            rxBitCnt <= '0;
        end else begin
            rxSync1 <= rx;
            rxSync2 <= rxSync1;
            rxPrev  <= rxSync2;
            case (rxState)
                IDLE:  if (rxStart) rxState <= START;
                START: if (rxTick) begin
                    rxBitCnt <= '0;
                    rxState  <= rxSync2 ? IDLE : DATA;
                end
                DATA: if (rxTick) begin
                    rxShift  <= {rxSync2, rxShift[7:1]};
                    rxBitCnt <= rxBitCnt + 3'd1;
                    if (rxBitCnt == 3'd7) rxState <= STOP;
                end
                STOP: if (rxTick) rxState <= IDLE;
                default: rxState <= IDLE;
            endcase
        end
    end

    // Hardware set takes priority over a same-cycle write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxData       <= '0;
            rxValid      <= 1'b0;
            rxOverrun    <= 1'b0;
            framingError <= 1'b0;
        end else begin
            if (rxStopOk) rxData <= rxShift;

            if (rxStopOk) rxValid <= 1'b1;
            else if (statusWr && dataIn[ST_RX_VALID]) rxValid <= 1'b0;

            if (rxStopOk && rxValid) rxOverrun <= 1'b1;
            else if (statusWr && dataIn[ST_RX_OVERRUN]) rxOverrun <= 1'b0;

            if (rxStopBad) framingError <= 1'b1;
            else if (statusWr && dataIn[ST_FRAMING]) framingError <= 1'b0;
        end
    end

    always_comb begin
        dataOut = 8'h00;
        if (readEnable) begin
            case (regSelect)
                REG_DATA:   dataOut = rxData;
                REG_STATUS: dataOut = status;
                REG_DIV:    dataOut = divisor;
                default:    dataOut = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io1_uart.sv
// Bench for io1_uart: register reads and TX frames are checked against expectation queues by monitors.
module tb_io1_uart;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       readEnable = 1'b0;
    logic       writeEnable = 1'b0;
    logic [1:0] regSelect = 2'b00;
    logic [7:0] dataIn = 8'h00;
    logic [7:0] dataOut;
    logic       rx = 1'b1;
    logic       tx;

    int total = 0;
    int bad = 0;
    int bitPeriod = 16;
    bit txMonEn = 1'b1;

    typedef struct {
        string      nm;
        logic [7:0] exp;
    } rdExp_t;

    rdExp_t     rdQ[$];
    rdExp_t     rdCur;
    logic [7:0] txQ[$];
    logic [7:0] txExpByte;
    logic [9:0] txFr;

    io1_uart #(.PRESCALE(16), .DIV_RESET(8'd0)) dut (
        .clk(clk), .reset(reset), .readEnable(readEnable), .writeEnable(writeEnable),
        .regSelect(regSelect), .dataIn(dataIn), .dataOut(dataOut), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string nm);
        rdExp_t e;
        @(posedge clk);
        #1;
        regSelect = sel;
        readEnable = 1'b1;
        e.nm = nm;
        e.exp = exp;
        rdQ.push_back(e);
        @(negedge clk);
        #1;
        readEnable = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        @(posedge clk);
        #1;
        regSelect = sel;
        dataIn = d;
        writeEnable = 1'b1;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
    endtask

    task automatic rxSend(input logic [7:0] b, input logic stopBit);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (bitPeriod) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (bitPeriod) @(posedge clk);
        end
        #1 rx = stopBit;
        repeat (bitPeriod) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    // Read monitor: every cycle the bus reads, compare against the oldest expectation.
    always @(negedge clk) begin
        if (readEnable) begin
            if (rdQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got read of %0h with no expectation queued", dataOut);
            end else begin
                rdCur = rdQ.pop_front();
                chk(rdCur.nm, dataOut, rdCur.exp);
            end
        end
    end

    // TX monitor: decode a frame mid-bit from its start edge and compare all 10 bits.
    initial begin
        forever begin
            @(negedge tx);
            if (txMonEn) begin
                repeat (bitPeriod / 2) @(posedge clk);
                #1 txFr[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (bitPeriod) @(posedge clk);
                    #1 txFr[i] = tx;
                end
                if (txQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got frame %0h with no expectation queued", txFr);
                end else begin
                    txExpByte = txQ.pop_front();
                    chk("tx_frame", txFr, {1'b1, txExpByte, 1'b0});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion within 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_tx", tx, 1'b1);
        rd(REG_STATUS, 8'h00, "rst_status");
        rd(REG_DIV, 8'h00, "rst_div");
        rd(REG_DATA, 8'h00, "rst_data");

        // TX 0x55; a second write during the frame is dropped.
        txQ.push_back(8'h55);
        wr(REG_DATA, 8'h55);
        rd(REG_STATUS, 8'h01, "tx_busy_k1");
        repeat (38) @(posedge clk);
        wr(REG_DATA, 8'h0F);
        repeat (117) @(posedge clk);
        rd(REG_STATUS, 8'h01, "tx_busy_k159");
        rd(REG_STATUS, 8'h00, "tx_idle_k160");

        // RX single byte, reads without side effects, then W1C.
        rxSend(8'hA3, 1'b1);
        rd(REG_STATUS, 8'h02, "rxA3_status");
        rd(REG_STATUS, 8'h02, "rxA3_status_again");
        rd(REG_DATA, 8'hA3, "rxA3_data");
        @(posedge clk);
        #1 regSelect = REG_DATA;
        #1 chk("dout_gated", dataOut, 8'h00);
        rd(2'b11, 8'h00, "rsv_reg");
        wr(REG_STATUS, 8'h02);
        rd(REG_STATUS, 8'h00, "w1c_valid");

        // Overrun.
        rxSend(8'h11, 1'b1);
        rxSend(8'h22, 1'b1);
        rd(REG_STATUS, 8'h06, "ovr_status");
        rd(REG_DATA, 8'h22, "ovr_data");
        wr(REG_STATUS, 8'h04);
        rd(REG_STATUS, 8'h02, "w1c_ovr");
        wr(REG_STATUS, 8'hF1);
        rd(REG_STATUS, 8'h02, "w1c_ignored_bits");

        // Framing error: byte discarded, rxValid untouched.
        wr(REG_STATUS, 8'h02);
        rd(REG_STATUS, 8'h00, "pre_frame_clear");
        rxSend(8'h3C, 1'b0);
        rd(REG_STATUS, 8'h08, "fe_status");
        rd(REG_DATA, 8'h22, "fe_data_kept");
        wr(REG_STATUS, 8'h08);
        rd(REG_STATUS, 8'h00, "w1c_fe");

        // Short glitch must not set flags or leave the receiver out of step.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        rd(REG_STATUS, 8'h00, "glitch_status");
        rxSend(8'h5A, 1'b1);
        rd(REG_DATA, 8'h5A, "post_glitch_data");
        rd(REG_STATUS, 8'h02, "post_glitch_status");

        // Divisor 1: 32 clocks per bit, then reset mid-frame.
        wr(REG_DIV, 8'h01);
        rd(REG_DIV, 8'h01, "div_rd");
        bitPeriod = 32;
        txMonEn = 1'b0;
        wr(REG_DATA, 8'hFF);
        rd(REG_STATUS, 8'h03, "div_busy_k1");
        repeat (30) @(posedge clk);
        #1 chk("div_start_k31", tx, 1'b0);
        @(posedge clk);
        #1 chk("div_bit0_k32", tx, 1'b1);
        repeat (66) @(posedge clk);
        rd(REG_STATUS, 8'h03, "div_busy_k99");
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_async_tx", tx, 1'b1);
        rd(REG_STATUS, 8'h00, "rst_mid_status");
        rd(REG_DIV, 8'h00, "rst_mid_div");
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("tx_idle_after_abort", tx, 1'b1);

        repeat (5) @(posedge clk);
        chk("rd_queue_empty", rdQ.size(), 0);
        chk("tx_queue_empty", txQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
